multicycle_control: RTL

//  Main control FSM for the multicycle RV32 core: sequences the shared ALU, memory port, IR/PC registers and the

---
 rtl/multicycle_control_pkg.sv | 51 +++++
 rtl/multicycle_control_alu_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes
// and the select/operation codes driven onto the datapath muxes.
package multicycle_control_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_HALT     = 4'd10;

  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_RALU = 7'h33;
  localparam logic [6:0] OP_IALU = 7'h13;
  localparam logic [6:0] OP_BEQ  = 7'h63;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields onto the ALU operation code.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for register forms; addi may carry it in its immediate
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32 core: sequences fetch, decode,
// execute and writeback over the shared ALU and the handshaked memory port.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP  = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_op;
  logic       ready;
  logic [1:0] aluop;
  logic       memreq_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c;

  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (illegal_op) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RALU:      state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_op = 1'b1;
            state_d    = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ImmSrc     = IMM_I;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    ResultSrc  = RES_ALUOUT;
    AdrSrc     = 1'b0;
    memreq_c   = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        memreq_c  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irwrite_c = ready;
        pcwrite_c = ready;
      end
      // precompute the branch target while the opcode is being decoded
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc   = 1'b1;
        memreq_c = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        regwrite_c = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        memreq_c   = 1'b1;
        memwrite_c = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite_c = 1'b1;
      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        aluop     = ALUOP_SUB;
        pcwrite_c = Zero;
      end
      default: ;
    endcase
  end

  multicycle_control_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (ALUControl)
  );

  // strobes are gated by reset so an in-flight access aborts in the same cycle
  assign MemReq   = memreq_c   & rst_n;
  assign MemWrite = memwrite_c & rst_n;
  assign IRWrite  = irwrite_c  & rst_n;
  assign PCWrite  = pcwrite_c  & rst_n;
  assign RegWrite = regwrite_c & rst_n;
  assign Illegal  = illegal_q;
  assign State    = state_q;

endmodule
